chebyshev_clenshaw_engine: RTL and testbench

//  Parametrised successor to the sequential Chebyshev evaluator. Computes y = sum_{k=0..DEGREE} c_k*T_k(x)

---
 rtl/chebyshev_clenshaw_engine.sv | 197 +++++++++++++++++++
 tb/tb_chebyshev_clenshaw_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chebyshev_clenshaw_engine.sv
// -----------------------------------------------------------------------------
// chebyshev_clenshaw_engine
//
// Evaluates y = sum_{k=0..DEGREE} c_k * T_k(x) with the Clenshaw recurrence,
// one iteration per cycle on a single shared multiplier. Coefficients are read
// from an external ROM with one cycle of read latency.
//
// Ports
//   clock       in   1        rising-edge clock
//   resetn      in   1        asynchronous active-low reset
//   in_valid    in   1        x_in valid
//   in_ready    out  1        engine can accept x_in (IDLE only)
//   x_in        in   WL       evaluation point, signed Q1.(WL-1)
//   coeff_addr  out  AW       ROM address (registered)
//   coeff_in    in   CL       ROM data for the address of the previous cycle
//   out_valid   out  1        data_out/ovf valid, held until accepted
//   out_ready   in   1        downstream accepts the result
//   data_out    out  BW       y, signed, CL-1 fractional bits
//   ovf         out  1        a saturation happened during this evaluation
//   dbg_state   out  2        current FSM state (0 IDLE, 1 ITER, 2 FINAL, 3 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high exactly in IDLE; out_valid is high exactly in
// DONE and data_out/ovf do not change while out_valid is high.
// -----------------------------------------------------------------------------
module chebyshev_clenshaw_engine #(
  parameter int WL       = 16,
  parameter int CL       = 16,
  parameter int DEGREE   = 4,
  parameter int WIDENING = 3,
  localparam int BW      = CL + WIDENING + 1,
  localparam int AW      = $clog2(DEGREE + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] x_in,
  output logic [AW-1:0] coeff_addr,
  input  logic [CL-1:0] coeff_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] data_out,
  output logic          ovf,
  output logic [1:0]    dbg_state
);

  // Product width and the widened sum width used before clamping.
  localparam int PW = WL + BW;
  localparam int SW = BW + 2;

  // Round-half-up constant: half an LSB of the product after the shift.
  localparam logic signed [PW-1:0] RND = PW'(2 ** (WL - 2));

  localparam logic [BW-1:0] SAT_MAX = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0] SAT_MIN = {1'b1, {(BW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [WL-1:0] x_q, x_d;
  logic [BW-1:0] b1_q, b1_d;
  logic [BW-1:0] b2_q, b2_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] data_q, data_d;
  logic          ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Shared datapath: term = rq(x*b1) (doubled in ITER), sum = term - b2 + c.
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] b1_ext;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] rq_ext;
  logic signed [SW-1:0] term;
  logic signed [SW-1:0] b2_ext;
  logic signed [SW-1:0] c_ext;
  logic signed [SW-1:0] sum;
  logic [SW-BW:0]       sum_top;
  logic                 sat_hit;
  logic [BW-1:0]        sat_val;

  always_comb begin
    x_ext   = {{BW{x_q[WL-1]}}, x_q};
    b1_ext  = {{WL{b1_q[BW-1]}}, b1_q};
    // Low PW bits of the product are exact for two's complement operands.
    prod    = x_ext * b1_ext;
    // The shifted value always fits SW bits, so the truncating cast is safe.
    rq_ext  = SW'((prod + RND) >>> (WL - 1));
    term    = (state_q == S_ITER) ? (rq_ext <<< 1) : rq_ext;
    b2_ext  = {{2{b2_q[BW-1]}}, b2_q};
    c_ext   = {{(SW-CL){coeff_in[CL-1]}}, coeff_in};
    sum     = term - b2_ext + c_ext;
    // The sum fits BW bits only when every bit from BW-1 upward matches.
    sum_top = sum[SW-1:BW-1];
    sat_hit = !((&sum_top) || !(|sum_top));
    if (!sat_hit) begin
      sat_val = sum[BW-1:0];
    end else if (sum[SW-1]) begin
      sat_val = SAT_MIN;
    end else begin
      sat_val = SAT_MAX;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state. The ROM answers one cycle late, so the address register is
  // always loaded with the index needed in the cycle after next: k-1 is on the
  // bus while iteration k runs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    k_d     = k_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        addr_d = AW'(DEGREE);
        if (in_valid) begin
          x_d     = x_in;
          b1_d    = '0;
          b2_d    = '0;
          k_d     = AW'(DEGREE);
          ovf_d   = 1'b0;
          addr_d  = AW'(DEGREE - 1);
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        b2_d  = b1_q;
        b1_d  = sat_val;
        ovf_d = ovf_q | sat_hit;
        if (k_q == AW'(1)) begin
          // c_0 is already requested; park the address for the next run.
          addr_d  = AW'(DEGREE);
          state_d = S_FINAL;
        end else begin
          k_d    = k_q - AW'(1);
          addr_d = k_q - AW'(2);
        end
      end
      S_FINAL: begin
        data_d  = sat_val;
        ovf_d   = ovf_q | sat_hit;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      k_q     <= '0;
      addr_q  <= AW'(DEGREE);
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign coeff_addr = addr_q;
  assign data_out   = data_q;
  assign ovf        = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_chebyshev_clenshaw_engine.sv
// -----------------------------------------------------------------------------
// tb_chebyshev_clenshaw_engine
//
// Directed bench for chebyshev_clenshaw_engine. Two instances: the default
// configuration (BW=20) and a WIDENING=0 instance (BW=17) used to force
// saturation. Each has a registered ROM model. Expected {ovf, data_out}
// values are hand-computed and queued when an input is issued; a monitor per
// instance pops and compares whenever a result is handed over.
// -----------------------------------------------------------------------------
module tb_chebyshev_clenshaw_engine;

  localparam int BW  = 20;
  localparam int BW2 = 17;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock;
  logic resetn;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // DUT 1 (WIDENING=3)
  // ---------------------------------------------------------------------------
  logic          in_valid, in_ready, out_valid, out_ready, ovf;
  logic [15:0]   x_in, coeff_in;
  logic [2:0]    coeff_addr;
  logic [BW-1:0] data_out;
  logic [1:0]    dbg_state;
  logic [15:0]   rom [0:4];

  chebyshev_clenshaw_engine #(
    .WL(16), .CL(16), .DEGREE(4), .WIDENING(3)
  ) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .coeff_addr(coeff_addr), .coeff_in(coeff_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .ovf(ovf), .dbg_state(dbg_state)
  );

  always @(posedge clock) coeff_in <= rom[coeff_addr];

  // ---------------------------------------------------------------------------
  // DUT 2 (WIDENING=0)
  // ---------------------------------------------------------------------------
  logic           in_valid2, in_ready2, out_valid2, out_ready2, ovf2;
  logic [15:0]    x_in2, coeff_in2;
  logic [2:0]     coeff_addr2;
  logic [BW2-1:0] data_out2;
  logic [1:0]     dbg_state2;
  logic [15:0]    rom2 [0:4];

  chebyshev_clenshaw_engine #(
    .WL(16), .CL(16), .DEGREE(4), .WIDENING(0)
  ) dut2 (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid2), .in_ready(in_ready2), .x_in(x_in2),
    .coeff_addr(coeff_addr2), .coeff_in(coeff_in2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .data_out(data_out2), .ovf(ovf2), .dbg_state(dbg_state2)
  );

  always @(posedge clock) coeff_in2 <= rom2[coeff_addr2];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [BW:0]  exp_q[$];
  logic [BW2:0] exp2_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW:0] pk(input logic o, input int v);
    logic [BW-1:0] t;
    t = BW'(v);
    return {o, t};
  endfunction

  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL result: unexpected output 0x%0h with empty queue", data_out);
      end else begin
        check("result", {11'd0, ovf, data_out}, {11'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clock) begin
    if (resetn && out_valid2 && out_ready2) begin
      if (exp2_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL result2: unexpected output 0x%0h with empty queue", data_out2);
      end else begin
        check("result2", {14'd0, ovf2, data_out2}, {14'd0, exp2_q.pop_front()});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (DUT 1). All tasks start and end 1 time unit after a
  // rising edge.
  // ---------------------------------------------------------------------------
  task automatic start_eval(input logic [15:0] x, input logic push,
                            input logic [BW:0] e);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles", in_ready, guard);
    end
    if (push) exp_q.push_back(e);
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clock); #1;
    in_valid = 1'b0;
    x_in     = 16'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clock); #1;
      cyc++;
    end while (!out_valid && cyc < 40);
    if (!out_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL out_valid_timeout: no out_valid after %0d cycles", cyc);
    end
  endtask

  // Full evaluation with out_ready high: checks latency and the return to IDLE.
  task automatic run_eval(input string name, input logic [15:0] x,
                          input logic [BW:0] e);
    int cyc;
    start_eval(x, 1'b1, e);
    wait_valid(cyc);
    check({name, "_latency"}, cyc, 5);
    check({name, "_in_ready_done"}, in_ready, 0);
    @(posedge clock); #1;
    check({name, "_out_valid_drop"}, out_valid, 0);
    check({name, "_in_ready_idle"}, in_ready, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    logic seen;

    resetn     = 1'b0;
    in_valid   = 1'b0;
    x_in       = '0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    x_in2      = '0;
    out_ready2 = 1'b1;
    rom  = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    rom2 = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_coeff_addr", coeff_addr, 4);
    check("rst_state", dbg_state, 0);
    check("rst_out_valid2", out_valid2, 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // c0 = 0.25, x = 0 -> 0.25
    rom = '{16'h2000, 16'h0, 16'h0, 16'h0, 16'h0};
    run_eval("t1", 16'h0000, pk(1'b0, 8192));

    // c2 = 0.5, x = 0.5 -> 0.5*T2(0.5) = -0.25
    rom = '{16'h0, 16'h0, 16'h4000, 16'h0, 16'h0};
    run_eval("t2", 16'h4000, pk(1'b0, -8192));

    // c1 = 0x7FFF, x = -0.5 -> rq(-16384*32767) = -16383
    rom = '{16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0};
    run_eval("t3", 16'hC000, pk(1'b0, -16383));

    // Same coefficients, x = -1 -> -32767
    run_eval("xneg1", 16'h8000, pk(1'b0, -32767));

    // c3 = 0.5, x = 0.5 -> 0.5*T3(0.5) = -0.5
    rom = '{16'h0, 16'h0, 16'h0, 16'h4000, 16'h0};
    run_eval("t3poly", 16'h4000, pk(1'b0, -16384));

    // Output stall: result and flags hold, x_in activity is ignored.
    rom = '{16'h2000, 16'h0, 16'h0, 16'h0, 16'h0};
    out_ready = 1'b0;
    start_eval(16'h0000, 1'b1, pk(1'b0, 8192));
    wait_valid(cyc);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      x_in     = 16'($urandom_range(0, 16'hFFFF));
      @(posedge clock); #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_data_out", data_out, 20'h02000);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("stall_release_in_ready", in_ready, 1);

    // Reset in the middle of iteration k=2 aborts the evaluation.
    rom = '{16'h0, 16'h0, 16'h4000, 16'h0, 16'h0};
    start_eval(16'h4000, 1'b0, '0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("abort_state_iter", dbg_state, 1);
    check("abort_addr_k2", coeff_addr, 1);
    resetn = 1'b0;
    #2;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_coeff_addr", coeff_addr, 4);
    @(posedge clock); #1;
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    run_eval("t2_after_abort", 16'h4000, pk(1'b0, -8192));

    // Saturation on the narrow instance: all c_k = 0x7FFF, x = 0x7FFF.
    rom2 = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    check("sat_in_ready2", in_ready2, 1);
    exp2_q.push_back({1'b1, 17'd32765});
    in_valid2 = 1'b1;
    x_in2     = 16'h7FFF;
    @(posedge clock); #1;
    in_valid2 = 1'b0;
    cyc = 0;
    while (!out_valid2 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("sat_latency2", cyc, 5);
    check("sat_ovf2_done", ovf2, 1);
    @(posedge clock); #1;

    // Next accept clears the sticky flag.
    rom2 = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    exp2_q.push_back({1'b0, 17'd0});
    in_valid2 = 1'b1;
    x_in2     = 16'h7FFF;
    @(posedge clock); #1;
    in_valid2 = 1'b0;
    check("ovf2_cleared_on_accept", ovf2, 0);
    cyc = 0;
    while (!out_valid2 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("clr_ovf2_done", ovf2, 0);
    @(posedge clock); #1;

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("queue2_drained", exp2_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
